// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and the round-robin search helper for the rr_mux_arbiter block.
// The search supports up to MAX_REQ requesters; callers zero-extend their request vectors.
package rr_arb_pkg;

   localparam int MAX_REQ          = 16;
   localparam int DEFAULT_N_REQ    = 4;
   localparam int DEFAULT_DATA_W   = 1;
   localparam int DEFAULT_HOLD_MAX = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arbState_t;

   // First set bit of reqVec scanning upward from start, wrapping at nReq-1 back to 0.
   function automatic logic [3:0] rrNextIndex(input logic [MAX_REQ-1:0] reqVec,
                                             input logic [3:0]         start,
                                             input logic [4:0]         nReq);
      logic [3:0] result;
      logic       found;
      logic [4:0] idx;
      result = '0;
      found  = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = 5'(start) + 5'(i);
         if (idx >= nReq) idx = idx - nReq;
         if (!found && (5'(i) < nReq) && reqVec[idx[3:0]]) begin
            result = idx[3:0];
            found  = 1'b1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_data_mux.sv
// N_REQ:1 combinational word mux with a valid-gated all-zeros output.
module rr_data_mux #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 1
) (
   input  logic [N_REQ*DATA_W-1:0]   i_data,
   input  logic [$clog2(N_REQ)-1:0]  i_sel,
   input  logic                      i_valid,
   output logic [DATA_W-1:0]         o_data
);

   localparam int SEL_W = $clog2(N_REQ);

   always_comb begin
      o_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (i_valid && (i_sel == SEL_W'(k))) o_data = i_data[k*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning one shared output mux, with bounded hold time per grantee.
// Optional macro ARB_LOCK_EN adds a lock input that defers hold-time preemption.
module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N_REQ    = DEFAULT_N_REQ,
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int HOLD_MAX = DEFAULT_HOLD_MAX
) (
   input  logic                      clk,
   input  logic                      rst,
`ifdef ARB_LOCK_EN
   input  logic                      lock,
`endif
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   data_in,
   output logic [N_REQ-1:0]          gnt,
   output logic                      gnt_valid,
   output logic [$clog2(N_REQ)-1:0]  sel,
   output logic [DATA_W-1:0]         data_out
);

   localparam int SEL_W  = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(HOLD_MAX + 1);

   arbState_t           r_state;
   logic [N_REQ-1:0]    r_gnt;
   logic [SEL_W-1:0]    r_sel;
   logic [HOLD_W-1:0]   r_holdCnt;
   logic [SEL_W-1:0]    r_prioPtr;

   arbState_t           w_nextState;
   logic [N_REQ-1:0]    w_nextGnt;
   logic [SEL_W-1:0]    w_nextSel;
   logic [HOLD_W-1:0]   w_nextHold;
   logic [SEL_W-1:0]    w_nextPrio;
   logic [N_REQ-1:0]    w_others;
   logic [SEL_W-1:0]    w_idleIdx;
   logic [SEL_W-1:0]    w_rrIdx;
   logic [SEL_W-1:0]    w_grantIdx;
   logic                w_newGrant;
   logic                w_clearGrant;
   logic                w_holdAtMax;
   logic                w_lock;
   logic                w_gntValid;

`ifdef ARB_LOCK_EN
   assign w_lock = lock;
`else
   assign w_lock = 1'b0;
`endif

   // The current grantee is masked out so a handoff never lands back on it.
   assign w_others    = req & ~r_gnt;
   assign w_idleIdx   = SEL_W'(rrNextIndex(MAX_REQ'(req), 4'(r_prioPtr), 5'(N_REQ)));
   assign w_rrIdx     = SEL_W'(rrNextIndex(MAX_REQ'(w_others), 4'(r_sel + SEL_W'(1)), 5'(N_REQ)));
   assign w_holdAtMax = (r_holdCnt == HOLD_W'(HOLD_MAX));

   always_comb begin
      w_nextState  = r_state;
      w_nextSel    = r_sel;
      w_nextHold   = r_holdCnt;
      w_nextPrio   = r_prioPtr;
      w_newGrant   = 1'b0;
      w_clearGrant = 1'b0;
      w_grantIdx   = r_sel;
      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               w_newGrant  = 1'b1;
               w_grantIdx  = w_idleIdx;
               w_nextState = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!req[r_sel]) begin
               if (|w_others) begin
                  w_newGrant = 1'b1;
                  w_grantIdx = w_rrIdx;
               end else begin
                  w_clearGrant = 1'b1;
                  w_nextHold   = '0;
                  w_nextState  = ST_IDLE;
               end
            end else if (w_holdAtMax && !w_lock) begin
               if (|w_others) begin
                  w_newGrant = 1'b1;
                  w_grantIdx = w_rrIdx;
               end else begin
                  w_nextHold = HOLD_W'(1);
               end
            end else if (!w_holdAtMax) begin
               w_nextHold = r_holdCnt + HOLD_W'(1);
            end
         end
      endcase
      if (w_newGrant) begin
         w_nextSel  = w_grantIdx;
         w_nextHold = HOLD_W'(1);
         w_nextPrio = w_grantIdx + SEL_W'(1);
      end
   end

   always_comb begin
      w_nextGnt = r_gnt;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_newGrant)        w_nextGnt[k] = (w_grantIdx == SEL_W'(k));
         else if (w_clearGrant) w_nextGnt[k] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_sel     <= '0;
         r_holdCnt <= '0;
         r_prioPtr <= '0;
      end else begin
         r_state   <= w_nextState;
         r_gnt     <= w_nextGnt;
         r_sel     <= w_nextSel;
         r_holdCnt <= w_nextHold;
         r_prioPtr <= w_nextPrio;
      end
   end

   assign w_gntValid = |r_gnt;
   assign gnt        = r_gnt;
   assign gnt_valid  = w_gntValid;
   assign sel        = r_sel;

   rr_data_mux #(
      .N_REQ  (N_REQ),
      .DATA_W (DATA_W)
   ) u_dataMux (
      .i_data  (data_in),
      .i_sel   (r_sel),
      .i_valid (w_gntValid),
      .o_data  (data_out)
   );

endmodule
